// File: rtl/add64_seq_ctrl.sv
// Sequential W-bit adder that drives an external combinational RCA16 slice one 16-bit slice per cycle.
// Optional subtract support is compiled in when ADD64_SEQ_SUB_EN is defined.
module add64_seq_ctrl #(
   parameter int NSLICE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [16*NSLICE-1:0]   a,
   input  logic [16*NSLICE-1:0]   b,
   input  logic                   cIn,
   input  logic                   sub,
   output logic                   busy,
   output logic                   done,
   output logic [16*NSLICE-1:0]   s,
   output logic                   cOut,
   output logic                   ovf,
   output logic [15:0]            slcA,
   output logic [15:0]            slcB,
   output logic                   slcCin,
   input  logic [15:0]            slcS,
   input  logic                   slcCout
);

   localparam int W     = 16 * NSLICE;
   localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [W-1:0]       op_a, op_b;
   logic [W-1:0]       b_eff;
   logic               cin_eff;
   logic               carry;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        lsb;
   logic               last;
   logic               accept;

   function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

`ifdef ADD64_SEQ_SUB_EN
   // a - b is formed as a + ~b + 1; the caller's carry-in is overridden.
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | cIn;
`else
   logic sub_unused;
   assign sub_unused = sub;
   assign b_eff      = b;
   assign cin_eff    = cIn;
`endif

   assign accept = (state == IDLE) && start;
   assign last   = (idx == IDX_W'(NSLICE - 1));
   assign lsb    = 32'(idx) << 4;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      done   = (state == DONE);
      slcA   = '0;
      slcB   = '0;
      slcCin = 1'b0;
      if (state == RUN) begin
         slcA   = op_a[lsb +: 16];
         slcB   = op_b[lsb +: 16];
         slcCin = carry;
      end
   end

   // Operand latches: only written on an accepted start, so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= a;
         op_b <= b_eff;
      end
   end

   // Slice stage: capture the slice sum and ripple the carry into the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry <= 1'b0;
         idx   <= '0;
         s     <= '0;
         cOut  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  carry <= cin_eff;
                  idx   <= '0;
               end
            end
            RUN: begin
               s[lsb +: 16] <= slcS;
               carry        <= slcCout;
               idx          <= idx + IDX_W'(1);
               if (last) begin
                  cOut <= slcCout;
                  ovf  <= ovf_detect(op_a[W-1], op_b[W-1], slcS[15]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Self-checking bench for add64_seq_ctrl: vector table plus scoreboard, with an RCA16 slice model.
// Expectations follow ADD64_SEQ_SUB_EN when it is defined.
module tb_add64_seq_ctrl;

   localparam int NSLICE = 4;
   localparam int W      = 16 * NSLICE;

   logic           clk = 1'b0;
   logic           rst, start, cIn, sub;
   logic [W-1:0]   a, b;
   logic           busy, done, cOut, ovf;
   logic [W-1:0]   s;
   logic [15:0]    slcA, slcB, slcS;
   logic           slcCin, slcCout;

   add64_seq_ctrl #(.NSLICE(NSLICE)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cIn(cIn), .sub(sub),
      .busy(busy), .done(done), .s(s), .cOut(cOut), .ovf(ovf),
      .slcA(slcA), .slcB(slcB), .slcCin(slcCin), .slcS(slcS), .slcCout(slcCout)
   );

   // Behavioural RCA16 slice.
   assign {slcCout, slcS} = {1'b0, slcA} + {1'b0, slcB} + {16'd0, slcCin};

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      exp_t         e;
   } vec_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc);
      exp_t r;
      {r.cout, r.s} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      r.ovf = (ra[W-1] == rb[W-1]) && (r.s[W-1] != ra[W-1]);
      return r;
   endfunction

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", {{(W-1){1'b0}}, done}, '0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_s",    s, e.s);
            check("result_cout", {{(W-1){1'b0}}, cOut}, {{(W-1){1'b0}}, e.cout});
            check("result_ovf",  {{(W-1){1'b0}}, ovf},  {{(W-1){1'b0}}, e.ovf});
         end
      end
   end

   // Called on the negedge after edge `lat`; done must first appear after edge NSLICE.
   task automatic wait_done(input int lat, input string nm, input exp_t e);
      int n = lat;
      while (done !== 1'b1 && n < NSLICE + 8) begin
         check({nm, "_busy_run"}, {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) check({nm, "_timeout"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
      check({nm, "_latency"}, W'(n), W'(NSLICE));
      @(negedge clk);
      check({nm, "_done_pulse"}, {{(W-1){1'b0}}, done}, '0);
      check({nm, "_busy_idle"},  {{(W-1){1'b0}}, busy}, '0);
      check({nm, "_s_hold"},     s, e.s);
      check({nm, "_slcA_idle"},  {{(W-16){1'b0}}, slcA}, '0);
   endtask

   task automatic run_op(input vec_t v, input string nm);
      @(negedge clk);
      a = v.a; b = v.b; cIn = v.cin; sub = v.sub; start = 1'b1;
      exp_q.push_back(v.e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(0, nm, v.e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      vec_t v;
      exp_t e;

      vecs[0] = '{64'd32, 64'd64, 1'b0, 1'b0, '{64'd96, 1'b0, 1'b0}};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd4, 1'b1, 1'b0, '{64'd0, 1'b1, 1'b0}};
      vecs[2] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, '{64'h1_0000, 1'b0, 1'b0}};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'h8000_0000_0000_0000, 1'b0, 1'b1}};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, '{64'd0, 1'b1, 1'b1}};
      vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
                  '{64'h2222_2222_2222_2212, 1'b0, 1'b0}};
`ifdef ADD64_SEQ_SUB_EN
      vecs[6] = '{64'd5, 64'd7, 1'b0, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}};
      vecs[7] = '{64'd7, 64'd7, 1'b0, 1'b1, '{64'd0, 1'b1, 1'b0}};
`else
      vecs[6] = '{64'd5, 64'd7, 1'b0, 1'b1, '{64'd12, 1'b0, 1'b0}};
      vecs[7] = '{64'd7, 64'd7, 1'b0, 1'b1, '{64'd14, 1'b0, 1'b0}};
`endif

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cIn = 1'b0; sub = 1'b0;

      // Reset state after two reset cycles.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_busy",   {{(W-1){1'b0}}, busy},   '0);
      check("rst_done",   {{(W-1){1'b0}}, done},   '0);
      check("rst_s",      s, '0);
      check("rst_cout",   {{(W-1){1'b0}}, cOut},   '0);
      check("rst_ovf",    {{(W-1){1'b0}}, ovf},    '0);
      check("rst_slcA",   {{(W-16){1'b0}}, slcA},  '0);
      check("rst_slcB",   {{(W-16){1'b0}}, slcB},  '0);
      check("rst_slcCin", {{(W-1){1'b0}}, slcCin}, '0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 4; i++) begin
         v.a   = {$urandom, $urandom};
         v.b   = {$urandom, $urandom};
         v.cin = 1'($urandom_range(0, 1));
         v.sub = 1'b0;
         v.e   = ref_add(v.a, v.b, v.cin);
         run_op(v, $sformatf("rnd%0d", i));
      end

      // Start re-pulsed in cycle 2 with different operands must be ignored.
      @(negedge clk);
      a = 64'd100; b = 64'd23; cIn = 1'b0; sub = 1'b0; start = 1'b1;
      e = '{64'd123, 1'b0, 1'b0};
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a = 64'hFFFF_0000_FFFF_0000; b = 64'h1111_1111_1111_1111; cIn = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(2, "repulse", e);
      repeat (3) @(negedge clk);
      check("repulse_queue_empty", W'(exp_q.size()), '0);
      check("repulse_s_stable", s, 64'd123);

      // Reset in cycle 3 aborts the operation with no done.
      @(negedge clk);
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cIn = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {{(W-1){1'b0}}, busy}, '0);
      check("abort_done", {{(W-1){1'b0}}, done}, '0);
      check("abort_s",    s, '0);
      check("abort_cout", {{(W-1){1'b0}}, cOut}, '0);
      check("abort_ovf",  {{(W-1){1'b0}}, ovf},  '0);
      check("abort_slcA", {{(W-16){1'b0}}, slcA}, '0);
      repeat (NSLICE + 2) @(negedge clk);
      run_op(vecs[0], "after_abort");

      // Reset wins over a simultaneous start.
      @(negedge clk);
      a = 64'd1; b = 64'd2; start = 1'b1; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      check("rst_prio_busy", {{(W-1){1'b0}}, busy}, '0);
      repeat (NSLICE + 2) @(negedge clk);
      check("rst_prio_s", s, '0);
      run_op(vecs[3], "after_prio");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
